// File: rtl/pic_pkg.sv
// pic_pkg -- shared encodings for the interrupt controller slice.
//   * command-word type codes carried on `flag`
//   * read-source select codes carried on `read_sel`
//   * OCW2 end-of-interrupt command codes (OCW2[7:5])
//   * FSM state type and state constants
package pic_pkg;

  // Command word type on flag
  localparam logic [2:0] FLAG_ICW1 = 3'd0;
  localparam logic [2:0] FLAG_ICW2 = 3'd1;
  localparam logic [2:0] FLAG_ICW3 = 3'd2;
  localparam logic [2:0] FLAG_ICW4 = 3'd3;
  localparam logic [2:0] FLAG_OCW1 = 3'd4;
  localparam logic [2:0] FLAG_OCW2 = 3'd5;
  localparam logic [2:0] FLAG_OCW3 = 3'd6;

  // Read source on read_sel; any other code reads IRR
  localparam logic [2:0] RSEL_IRR     = 3'b001;
  localparam logic [2:0] RSEL_IRR_ALT = 3'b111;
  localparam logic [2:0] RSEL_ISR     = 3'b101;
  localparam logic [2:0] RSEL_IMR     = 3'b011;

  // OCW2[7:5] end-of-interrupt commands
  localparam logic [2:0] EOI_NONSPEC = 3'b001;
  localparam logic [2:0] EOI_SPEC    = 3'b011;

  // Acknowledge FSM
  typedef logic [1:0] pic_state_t;
  localparam pic_state_t ST_IDLE = 2'd0;
  localparam pic_state_t ST_PEND = 2'd1;
  localparam pic_state_t ST_ACK1 = 2'd2;
  localparam pic_state_t ST_ACK2 = 2'd3;

  // Level reported when the acknowledge finds nothing to service
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/pic_control_logic_if.sv
// pic_control_logic_if -- bundle of the controller's command, read,
// interrupt and acknowledge signals.
//   master : drives cw_valid/flag/cw_data, rd_valid/read_sel, ir, inta_n;
//            observes int_out/data_out/data_oe
//   slave  : the controller side of the same signals
// Handshake: cw_valid and rd_valid are single-cycle strobes with no ready;
// the controller always accepts them in the cycle they are high.
interface pic_control_logic_if;
  logic       cw_valid;
  logic [2:0] flag;
  logic [7:0] cw_data;
  logic       rd_valid;
  logic [2:0] read_sel;
  logic [7:0] ir;
  logic       inta_n;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output cw_valid, flag, cw_data, rd_valid, read_sel, ir, inta_n,
                  input  int_out, data_out, data_oe);
  modport slave  (input  cw_valid, flag, cw_data, rd_valid, read_sel, ir, inta_n,
                  output int_out, data_out, data_oe);
endinterface

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver -- fully nested priority search.
//   irr, imr, isr : request, mask and in-service registers
//   valid         : a serviceable request exists
//   level         : its index (IR0 highest priority)
// A request at index n qualifies only when unmasked and strictly above
// (lower index than) every in-service level.
module pic_priority_resolver (
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       valid,
  output logic [2:0] level
);

  logic [7:0] req;
  logic       blocked;

  always_comb begin
    req     = irr & ~imr;
    valid   = 1'b0;
    level   = 3'd0;
    blocked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // An in-service bit blocks its own level and everything below it.
      if (isr[i]) blocked = 1'b1;
      if (!blocked && !valid && req[i]) begin
        valid = 1'b1;
        level = 3'(i);
      end
    end
  end

endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic -- 8-input interrupt controller control path.
//   clk, reset        : clock, synchronous active-high reset
//   cw_valid/flag/cw_data : command-word write (ICW1..4, OCW1..3)
//   rd_valid/read_sel : register read, answered one cycle later
//   ir                : request lines;  inta_n : acknowledge (active low)
//   int_out           : interrupt to CPU (high exactly while pending)
//   data_out/data_oe  : read data or acknowledge vector
// Optional feature macro: PIC_AUTO_EOI_EN (automatic EOI when ICW4[1]=1).
module pic_control_logic
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cw_valid,
  input  logic [2:0] flag,
  input  logic [7:0] cw_data,
  input  logic       rd_valid,
  input  logic [2:0] read_sel,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] data_out,
  output logic       data_oe
);

  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [7:0] ocw2_q, ocw2_d, ocw3_q, ocw3_d;
  logic [7:0] imr_q, imr_d, isr_q, isr_d, irr_q, irr_d, ir_prev_q, ir_prev_d;
  logic       inta_prev_q, inta_prev_d, init_done_q, init_done_d;
  pic_state_t state_q, state_d;
  logic [2:0] lvl_q, lvl_d;
  logic       int_out_q, int_out_d, data_oe_q, data_oe_d;
  logic [7:0] data_out_q, data_out_d;

  logic       cand_valid;
  logic [2:0] cand_level;
  logic       inta_fall, inta_rise, in_ack, ltim, ack_entry;
  logic       unused_bits;

  pic_priority_resolver u_resolver (
    .irr   (irr_q),
    .imr   (imr_q),
    .isr   (isr_q),
    .valid (cand_valid),
    .level (cand_level)
  );

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;
  assign in_ack    = (state_q == ST_ACK1) || (state_q == ST_ACK2);
  assign ltim      = icw1_q[3];

  always_comb begin
    icw1_d = icw1_q;  icw2_d = icw2_q;  icw3_d = icw3_q;  icw4_d = icw4_q;
    ocw2_d = ocw2_q;  ocw3_d = ocw3_q;
    imr_d = imr_q;  isr_d = isr_q;  irr_d = irr_q;
    ir_prev_d   = ir;
    inta_prev_d = inta_n;
    init_done_d = init_done_q;
    state_d     = state_q;
    lvl_d       = lvl_q;
    ack_entry   = 1'b0;

    // Request capture: level mode freezes IRR while the acknowledge runs.
    if (ltim) begin
      if (!in_ack) irr_d = ir;
    end else begin
      irr_d = irr_q | (ir & ~ir_prev_q);
    end

    // End of interrupt from OCW2; isr & (isr - 1) drops the lowest set bit.
    if (cw_valid && flag == FLAG_OCW2) begin
      case (cw_data[7:5])
        EOI_NONSPEC: isr_d = isr_q & (isr_q - 8'd1);
        EOI_SPEC:    isr_d[cw_data[2:0]] = 1'b0;
        default:     ;
      endcase
    end

    case (state_q)
      ST_IDLE: if (init_done_q && cand_valid) state_d = ST_PEND;
      ST_PEND: if (inta_fall) begin
        state_d   = ST_ACK1;
        ack_entry = 1'b1;
        lvl_d     = cand_valid ? cand_level : SPURIOUS_LEVEL;
      end
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: if (inta_rise) begin
        state_d = ST_IDLE;
`ifdef PIC_AUTO_EOI_EN
        if (icw4_q[1]) isr_d[lvl_q] = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A spurious acknowledge (no candidate) leaves ISR and IRR untouched.
    if (ack_entry && cand_valid) begin
      isr_d[cand_level] = 1'b1;
      if (!ltim) irr_d[cand_level] = 1'b0;
    end

    if (cw_valid) begin
      case (flag)
        FLAG_ICW1: icw1_d = cw_data;
        FLAG_ICW2: begin
          icw2_d = cw_data;
          if (icw1_q[1] && !icw1_q[0]) init_done_d = 1'b1;
        end
        FLAG_ICW3: begin
          icw3_d = cw_data;
          if (!icw1_q[0]) init_done_d = 1'b1;
        end
        FLAG_ICW4: begin icw4_d = cw_data; init_done_d = 1'b1; end
        FLAG_OCW1: begin imr_d  = cw_data; init_done_d = 1'b1; end
        FLAG_OCW2: begin ocw2_d = cw_data; init_done_d = 1'b1; end
        FLAG_OCW3: begin ocw3_d = cw_data; init_done_d = 1'b1; end
        default:   ;
      endcase
    end

    // ICW1 restarts initialisation and wins over everything above.
    if (cw_valid && flag == FLAG_ICW1) begin
      imr_d = 8'h00;  isr_d = 8'h00;  irr_d = 8'h00;  ir_prev_d = 8'h00;
      init_done_d = 1'b0;
      state_d     = ST_IDLE;
    end

    // Outputs are registered from the next state so they track it exactly.
    int_out_d  = (state_d == ST_PEND);
    data_oe_d  = 1'b0;
    data_out_d = 8'h00;
    if (state_d == ST_ACK2) begin
      data_oe_d  = 1'b1;
      data_out_d = {icw2_q[7:3], lvl_q};
    end else if (rd_valid && !in_ack) begin
      data_oe_d = 1'b1;
      case (read_sel)
        RSEL_ISR:               data_out_d = isr_q;
        RSEL_IMR:               data_out_d = imr_q;
        RSEL_IRR, RSEL_IRR_ALT: data_out_d = irr_q;
        default:                data_out_d = irr_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icw1_q <= '0;  icw2_q <= '0;  icw3_q <= '0;  icw4_q <= '0;
      ocw2_q <= '0;  ocw3_q <= '0;
      imr_q  <= '0;  isr_q  <= '0;  irr_q  <= '0;  ir_prev_q <= '0;
      inta_prev_q <= 1'b1;
      init_done_q <= 1'b0;
      state_q     <= ST_IDLE;
      lvl_q       <= '0;
      int_out_q   <= 1'b0;
      data_oe_q   <= 1'b0;
      data_out_q  <= '0;
    end else begin
      icw1_q <= icw1_d;  icw2_q <= icw2_d;  icw3_q <= icw3_d;  icw4_q <= icw4_d;
      ocw2_q <= ocw2_d;  ocw3_q <= ocw3_d;
      imr_q  <= imr_d;   isr_q  <= isr_d;   irr_q  <= irr_d;   ir_prev_q <= ir_prev_d;
      inta_prev_q <= inta_prev_d;
      init_done_q <= init_done_d;
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      int_out_q   <= int_out_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
    end
  end

  assign int_out  = int_out_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

  // Stored command bits that no logic here consumes.
  assign unused_bits = ^{icw1_q, icw2_q[2:0], icw3_q, icw4_q, ocw2_q, ocw3_q};

endmodule

// File: doc/pic_control_logic.md
PIC_CONTROL_LOGIC -- requirements
Module: pic_control_logic

Interface
REQ-001 The block SHALL have the following ports.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cw_valid  in  1  one-cycle strobe: flag/cw_data hold a newly written command word.
- flag  in  3  word type: 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4, 4=OCW1, 5=OCW2, 6=OCW3.
- cw_data  in  8  command word byte.
- rd_valid  in  1  one-cycle read strobe.
- read_sel  in  3  source: 001/111=IRR, 101=ISR, 011=IMR.
- ir  in  8  interrupt request lines, synchronous to clk.
- inta_n  in  1  interrupt acknowledge, active-low, synchronous to clk.
- int_out  out  1  interrupt request to CPU.
- data_out  out  8  read data or vector.
- data_oe  out  1  data_out valid.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 Each cw_valid SHALL store cw_data in the register selected by flag; OCW1 SHALL load IMR.
REQ-004 flag=0 SHALL clear IMR, ISR, IRR, the edge history and init_done, and force FSM to IDLE, overriding any other same-cycle event.
REQ-005 init_done SHALL set on: ICW2 when ICW1[1]=1 and ICW1[0]=0; ICW3 when ICW1[0]=0; ICW4; any OCW.
REQ-006 LTIM=ICW1[3]=0: IRR[n] SHALL set on a 0->1 transition of ir[n] versus the previous cycle; LTIM=1: IRR[n] SHALL follow ir[n] except during ACK1/ACK2.
REQ-007 Candidate = lowest index n with IRR[n]=1, IMR[n]=0 and n below the lowest set ISR bit (IR0 highest priority, fully nested).
REQ-008 FSM states: IDLE, PEND, ACK1, ACK2.
- IDLE->PEND when init_done=1 and a candidate exists.
- PEND->ACK1 on an inta_n falling edge.
- ACK1->ACK2 on the next inta_n falling edge.
- ACK2->IDLE on an inta_n rising edge.
REQ-009 int_out SHALL be registered and SHALL equal 1 exactly while the FSM is in PEND.
REQ-010 On entry to ACK1, the block SHALL latch the candidate level L, set ISR[L] and clear IRR[L] (edge mode).
- If no candidate exists, L SHALL be 7 and ISR SHALL be unchanged (spurious).
REQ-011 In ACK2, data_out SHALL be {ICW2[7:3],L} and data_oe=1 from the cycle after the falling edge until the rising edge.
REQ-012 OCW2[7:5]=001 SHALL clear the lowest-index set ISR bit; 011 SHALL clear ISR[OCW2[2:0]]; other codes SHALL be ignored.
REQ-013 rd_valid outside ACK1/ACK2 SHALL drive the selected register on data_out with data_oe=1 for exactly one cycle, one cycle later; an unlisted read_sel SHALL return IRR.
REQ-014 IRR/ISR/IMR updates in the same cycle as a read SHALL be visible on the following read only.

Reset
REQ-015 reset SHALL force int_out=0, data_out=0, data_oe=0, IMR=ISR=IRR=0, ICW registers=0, init_done=0 and FSM=IDLE.
REQ-016 reset mid-acknowledge SHALL abandon the cycle with no vector driven.

Configuration
REQ-017 With PIC_AUTO_EOI_EN defined and ICW4[1]=1, ISR[L] SHALL clear at the ACK2->IDLE transition.
- Without the macro, ICW4[1] SHALL be ignored and ISR SHALL clear only by OCW2.

Structure
REQ-018 The flag encodings, read_sel encodings, OCW2 EOI codes and the FSM state type SHALL live in shared package pic_pkg.
REQ-019 The candidate search SHALL be sub-module pic_priority_resolver (inputs IRR, IMR, ISR; outputs valid and level).

Verification
REQ-020 The bench SHALL cover these directed scenarios.
- ICW1=0x13, ICW2=0x20, ICW4=0x01, OCW1=0x00; rising edge on ir[3]; two INTA pulses -> int_out=1 in PEND, data_out=0x23 in ACK2, ISR=0x08.
- ISR=0x08; raise ir[5] -> int_out stays 0; raise ir[1] -> int_out=1, vector 0x21.
- OCW1=0xFF; toggle ir[0] -> int_out stays 0; OCW1=0x00 -> int_out=1.
- ISR=0x0A; OCW2=0x20 -> ISR=0x08; OCW2=0x63 -> ISR=0x00.
- ir[2] pulses, then drops before the first INTA (LTIM=1) -> vector 0x27, ISR unchanged.
- PIC_AUTO_EOI_EN defined, ICW4=0x03 -> ISR=0x00 after the final INTA rising edge; OCW3=0x0B then read_sel=101 -> ISR returned one cycle later.
